// File: rtl/wb_block_copier_pkg.sv
// ============================================================================
// wb_block_copier_pkg : state encoding and select constant for the copier
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_block_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Sliced down to SELECT_WIDTH by the master; every access is a full word.
  localparam logic [63:0] SEL_ALL_ONES = {64{1'b1}};

endpackage

`default_nettype wire

// File: rtl/wb_block_copier_watchdog.sv
// ============================================================================
// wb_block_copier_watchdog : counts enabled cycles, expires at TIMEOUT_CYCLES
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_block_copier_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] count;

  // expire flags the TIMEOUT_CYCLES-th enabled cycle itself, so the owner
  // can abort on the same edge instead of one cycle late.
  assign expire = en && (count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_block_copier.sv
// ============================================================================
// wb_block_copier : Wishbone classic master copying LEN words src -> dst
// Rev 1.0 -- optional fill mode under WB_BLOCK_COPIER_FILL_EN
// ============================================================================
`default_nettype none

module wb_block_copier
  import wb_block_copier_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_adr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_adr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic                    fill_i,
  input  logic [DATA_WIDTH-1:0]   fill_dat_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic                    m_we_o,
  output logic [SELECT_WIDTH-1:0] m_sel_o,
  output logic                    m_stb_o,
  output logic                    m_cyc_o,
  input  logic                    m_ack_i,
  input  logic                    m_stall_i
);

  localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);
  localparam logic [SELECT_WIDTH-1:0] SEL_ONES   = SEL_ALL_ONES[SELECT_WIDTH-1:0];

  state_t                state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  idx;
  logic [LEN_WIDTH-1:0]  idx_next;
  logic                  fill_mode;
  logic                  first;
  logic                  fill_req;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  expire;
  logic                  stall_abort;

`ifdef WB_BLOCK_COPIER_FILL_EN
  assign fill_req  = fill_i;
  assign fill_word = fill_dat_i;
`else
  assign fill_req  = 1'b0;
  assign fill_word = '0;
  logic unused_fill;
  assign unused_fill = ^{fill_i, fill_dat_i};
`endif

  function automatic logic [ADDR_WIDTH-1:0] word_adr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [LEN_WIDTH-1:0]  i
  );
    return (base + ADDR_WIDTH'(i) * ADDR_WIDTH'(SELECT_WIDTH)) & ALIGN_MASK;
  endfunction

  assign idx_next = idx + LEN_WIDTH'(1);

  // The responder registers its bad-address flag, so stall is only
  // meaningful from the second strobe cycle of each access.
  assign stall_abort = m_stb_o && !first && m_stall_i;

  wb_block_copier_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (!m_stb_o || m_ack_i),
    .en    (m_stb_o && !m_ack_i),
    .expire(expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      idx       <= '0;
      fill_mode <= 1'b0;
      first     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_stb_o   <= 1'b0;
      m_cyc_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            src       <= src_adr_i & ALIGN_MASK;
            dst       <= dst_adr_i & ALIGN_MASK;
            len       <= len_i;
            idx       <= '0;
            err_o     <= 1'b0;
            busy_o    <= 1'b1;
            fill_mode <= fill_req;
            if (len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_sel_o <= SEL_ONES;
              first   <= 1'b1;
              if (fill_req) begin
                state   <= ST_WR;
                m_we_o  <= 1'b1;
                m_adr_o <= dst_adr_i & ALIGN_MASK;
                m_dat_o <= fill_word;
              end else begin
                state   <= ST_RD;
                m_we_o  <= 1'b0;
                m_adr_o <= src_adr_i & ALIGN_MASK;
              end
            end
          end
        end

        ST_RD, ST_WR: begin
          first <= 1'b0;
          if (stall_abort || expire) begin
            state   <= ST_ERR;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            err_o   <= 1'b1;
            done_o  <= 1'b1;
          end else if (m_ack_i) begin
            first <= 1'b1;
            if (state == ST_RD) begin
              state   <= ST_WR;
              m_we_o  <= 1'b1;
              m_adr_o <= word_adr(dst, idx);
              m_dat_o <= m_dat_i;
            end else begin
              idx <= idx_next;
              if (idx_next == len) begin
                state   <= ST_DONE;
                m_cyc_o <= 1'b0;
                m_stb_o <= 1'b0;
                m_we_o  <= 1'b0;
                m_sel_o <= '0;
                done_o  <= 1'b1;
              end else if (fill_mode) begin
                m_adr_o <= word_adr(dst, idx_next);
                m_dat_o <= fill_word;
              end else begin
                state   <= ST_RD;
                m_we_o  <= 1'b0;
                m_adr_o <= word_adr(src, idx_next);
              end
            end
          end
        end

        ST_DONE, ST_ERR: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_block_copier.sv
// ============================================================================
// tb_wb_block_copier : scoreboard bench with a 1-cycle-ack RAM responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_block_copier;

  localparam int MEM_WORDS = 256;
`ifdef WB_BLOCK_COPIER_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_adr_i = '0;
  logic [31:0] dst_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        fill_i = 1'b0;
  logic [31:0] fill_dat_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_we_o, m_stb_o, m_cyc_o;
  logic [3:0]  m_sel_o;
  logic        ack = 1'b0;
  logic        stall = 1'b0;
  bit          silent = 1'b0;

  always #5 clk = ~clk;

  wb_block_copier #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .LEN_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
    .fill_i(fill_i), .fill_dat_i(fill_dat_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_stb_o(m_stb_o),
    .m_cyc_o(m_cyc_o), .m_ack_i(ack), .m_stall_i(stall)
  );

  // RAM responder: 1 KiB, acks one cycle after strobe, flags bad addresses.
  logic [31:0] mem   [MEM_WORDS];
  logic [31:0] model [MEM_WORDS];
  logic [31:0] snap  [MEM_WORDS];

  assign m_dat_i = (m_adr_o < 32'd1024) ? mem[m_adr_o[9:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (m_cyc_o && m_stb_o && m_we_o && ack && m_adr_o < 32'd1024)
      mem[m_adr_o[9:2]] = m_dat_o;
    ack   <= m_cyc_o && m_stb_o && !silent && (m_adr_o < 32'd1024) && !ack;
    stall <= m_cyc_o && m_stb_o && (m_adr_o >= 32'd1024);
  end

  typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } acc_t;
  typedef struct packed { logic err; logic [31:0] cyc; logic [31:0] wr_cyc; } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  acc_t  mon_a;
  done_t mon_d;

  int          errors = 0;
  int          checks = 0;
  int unsigned edge_n = 0;
  int unsigned e0 = 0;
  int unsigned stb_cyc = 0, wr_cyc = 0, busy_cyc = 0, done_seen = 0;
  logic        prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops scoreboard entries whenever the bus or done_o presents one.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (m_stb_o) stb_cyc++;
      if (m_stb_o && m_we_o) wr_cyc++;
      if (busy_o) busy_cyc++;
      if (prev_ack && m_stb_o)
        chk("no_reissue_after_ack", {63'd0, (m_adr_o == prev_adr) && (m_we_o == prev_we)}, 64'd0);
      prev_ack = m_stb_o && ack;
      prev_adr = m_adr_o;
      prev_we  = m_we_o;
      if (m_stb_o && ack) begin
        chk("sel_all_ones", {60'd0, m_sel_o}, 64'hF);
        if (acc_q.size() == 0) begin
          fail_now($sformatf("unexpected_access adr=%08h we=%0b", m_adr_o, m_we_o));
        end else begin
          mon_a = acc_q.pop_front();
          chk("access_we", {63'd0, m_we_o}, {63'd0, mon_a.we});
          chk("access_adr", {32'd0, m_adr_o}, {32'd0, mon_a.adr});
          if (mon_a.we) chk("write_data", {32'd0, m_dat_o}, {32'd0, mon_a.dat});
        end
      end
      if (done_o) begin
        done_seen++;
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_d = done_q.pop_front();
          chk("done_cycle", {32'd0, edge_n - e0}, {32'd0, mon_d.cyc});
          chk("err_flag", {63'd0, err_o}, {63'd0, mon_d.err});
          chk("busy_cycles", {32'd0, busy_cyc}, {32'd0, mon_d.cyc + 1});
          chk("stb_cycles", {32'd0, stb_cyc}, {32'd0, mon_d.cyc});
          chk("write_stb_cycles", {32'd0, wr_cyc}, {32'd0, mon_d.wr_cyc});
        end
      end
    end
  end

  // Reference model: a block move applied word by word in ascending order.
  task automatic model_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit f, input logic [31:0] fd);
    bit          fm;
    logic [31:0] sa, da, v;
    fm = FILL_ON && f;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      if (fm) begin
        v = fd;
      end else begin
        v = model[sa[9:2]];
        acc_q.push_back('{we: 1'b0, adr: sa, dat: 32'd0});
      end
      acc_q.push_back('{we: 1'b1, adr: da, dat: v});
      model[da[9:2]] = v;
    end
    done_q.push_back('{err: 1'b0, cyc: 32'(fm ? 2 * n : 4 * n), wr_cyc: 32'(2 * n)});
  endtask

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                       input bit f, input logic [31:0] fd);
    @(negedge clk);
    src_adr_i  = s;
    dst_adr_i  = d;
    len_i      = 16'(n);
    fill_i     = f;
    fill_dat_i = fd;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    e0       = edge_n;
    stb_cyc  = 0;
    wr_cyc   = 0;
    busy_cyc = 0;
  endtask

  task automatic wait_done(input int unsigned target);
    int k;
    k = 0;
    while (done_seen < target && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (done_seen < target) fail_now("done_timeout");
    repeat (2) @(posedge clk);
    chk("access_queue_drained", 64'(acc_q.size()), 64'd0);
  endtask

  task automatic good_job(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit f, input logic [31:0] fd);
    int unsigned t;
    t = done_seen + 1;
    model_job(s, d, n, f, fd);
    issue(s, d, n, f, fd);
    wait_done(t);
  endtask

  task automatic err_job(input logic [31:0] s, input logic [31:0] d, input int n, input int cyc);
    int unsigned t;
    t = done_seen + 1;
    done_q.push_back('{err: 1'b1, cyc: 32'(cyc), wr_cyc: 32'd0});
    issue(s, d, n, 1'b0, 32'd0);
    wait_done(t);
  endtask

  initial begin
    int          k, nbad, n;
    logic [31:0] s, d;

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]   = $urandom;
      model[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]   = 32'h11111111 * (i + 1);
      model[i] = mem[i];
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_cyc_stb_we", {61'd0, m_cyc_o, m_stb_o, m_we_o}, 64'd0);
    chk("rst_sel", {60'd0, m_sel_o}, 64'd0);
    chk("rst_adr_dat", {m_adr_o, m_dat_o}, 64'd0);
    rst_i = 1'b0;

    // Directed copy of four words
    good_job(32'h000, 32'h100, 4, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++)
      chk("copy_dest_word", {32'd0, mem[64 + i]}, {32'd0, 32'h11111111 * (i + 1)});
    chk("copy_err_clear", {63'd0, err_o}, 64'd0);

    // Zero length: no bus activity, done in cycle 0
    good_job(32'h010, 32'h180, 0, 1'b0, 32'd0);

    // Bad source address: stall abort before any write
    err_job(32'h1000, 32'h200, 2, 2);
    repeat (3) @(negedge clk);
    chk("err_held", {63'd0, err_o}, 64'd1);

    // Silent responder: watchdog abort after 8 strobe cycles
    silent = 1'b1;
    err_job(32'h000, 32'h300, 1, 8);
    silent = 1'b0;

    // Fill request (a plain copy when fill support is compiled out)
    good_job(32'h300, 32'h040, 3, 1'b1, 32'hDEADBEEF);

    // Randomized jobs, overlaps allowed
    for (int j = 0; j < 20; j++) begin
      s = 32'($urandom_range(0, 200)) * 4;
      d = 32'($urandom_range(0, 200)) * 4;
      if (d == s) d = d + 32'd4;
      n = $urandom_range(0, 6);
      good_job(s, d, n, 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset during the write of word index 2
    for (int i = 0; i < MEM_WORDS; i++) snap[i] = model[i];
    model_job(32'h080, 32'h280, 4, 1'b0, 32'd0);
    issue(32'h080, 32'h280, 4, 1'b0, 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_stb_o && m_we_o && m_adr_o == 32'h288 && !ack) && k < 100);
    if (k >= 100) fail_now("reset_point_timeout");
    rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc", {63'd0, m_cyc_o}, 64'd0);
    chk("rst_mid_stb", {63'd0, m_stb_o}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_no_done", {63'd0, done_o}, 64'd0);
    end
    acc_q.delete();
    done_q.delete();
    for (int i = 0; i < MEM_WORDS; i++) model[i] = snap[i];
    for (int i = 0; i < 2; i++) model[(32'h280 >> 2) + i] = model[(32'h080 >> 2) + i];
    rst_i = 1'b0;
    chk("rst_mid_err", {63'd0, err_o}, 64'd0);
    good_job(32'h080, 32'h280, 4, 1'b0, 32'd0);
    chk("fresh_copy_err", {63'd0, err_o}, 64'd0);

    nbad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== model[i]) nbad++;
    chk("final_memory_mismatch_words", 64'(nbad), 64'd0);
    chk("leftover_done_entries", 64'(done_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
